// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int SEL_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a range of register indices, captures each word and streams it out tagged with its index.
// Optional macro REGDUMP_PARITY_EN adds out_par, the XOR-reduce of each captured word.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  start_idx,
  input  logic [SEL_W:0]    count,
  output logic [SEL_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic              done
`ifdef REGDUMP_PARITY_EN
  ,
  output logic              out_par
`endif
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_data/out_idx stay stable while out_valid is high and out_ready is low.

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W:0]      rem_q, rem_d;
  logic [SEL_W-1:0]    rd_sel_q, rd_sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_idx_q, out_idx_d;
  logic                out_valid_q, out_valid_d;
`ifdef REGDUMP_PARITY_EN
  logic                out_par_q, out_par_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    rd_sel_d    = rd_sel_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
`ifdef REGDUMP_PARITY_EN
    out_par_d   = out_par_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            idx_d   = start_idx;
            rem_d   = count;
            state_d = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        rd_sel_d    = idx_q;
        out_data_d  = rd_data;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_PARITY_EN
        out_par_d   = ^rd_data;
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rem_q > (SEL_W+1)'(1)) begin
            rem_d   = rem_q - (SEL_W+1)'(1);
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            state_d = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      rd_sel_q    <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      rd_sel_q    <= rd_sel_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef REGDUMP_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

  // The mux select follows idx during FETCH and otherwise keeps the last index read.
  assign rd_sel    = (state_q == FETCH) ? idx_q : rd_sel_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader with a register-file model and an expected-word queue.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int NR = NUM_REGS_DEF;
  localparam int SW = SEL_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] start_idx = '0;
  logic [SW:0]   count = '0;
  logic [SW-1:0] rd_sel;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic [1:0]    dbg_state;
  logic          done;
`ifdef REGDUMP_PARITY_EN
  logic          out_par;
`endif

  logic [DW-1:0] regs [NR];
  assign rd_data = regs[rd_sel];

  regfile_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_idx (start_idx),
    .count     (count),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state),
    .done      (done)
`ifdef REGDUMP_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int valid_cycles = 0;
  int words_rx = 0;
  logic [SW+DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every transfer must match the head of exp_q
  always @(negedge clk) begin
    logic [SW+DW-1:0] e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        words_rx++;
        check_eq("word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("word", 64'({out_idx, out_data}), 64'(e));
`ifdef REGDUMP_PARITY_EN
          check_eq("word_par", 64'(out_par), 64'(^e[DW-1:0]));
`endif
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    done_cnt = 0;
    valid_cycles = 0;
    words_rx = 0;
    exp_q.delete();
  endtask

  task automatic expect_range(input int s, input int c);
    for (int k = 0; k < c; k++) begin
      int i;
      i = (s + k) % NR;
      exp_q.push_back({SW'(i), regs[i]});
    end
  endtask

  task automatic pulse_start(input int s, input int c);
    start_idx = SW'(s);
    count = (SW+1)'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_idx = SW'($urandom_range(0, NR-1));
    count = (SW+1)'($urandom_range(0, NR));
  endtask

  task automatic wait_done(input string tag, input int budget, input int nwords);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, 64'(done), 64'(1));
    tick();
    check_eq({tag, "_idle_after"}, 64'({busy, done}), 64'(0));
    check_eq({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check_eq({tag, "_words"}, 64'(words_rx), 64'(nwords));
    check_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_word(input string tag, input int idx, input int budget);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_idx === SW'(idx)) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_word_found"}, 64'(out_valid && out_idx == SW'(idx)), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = 32'hFFFF_FF00 + 32'(i);

    // reset state
    #2;
    check_eq("reset_async_outputs", 64'({out_valid, busy, done, out_idx, rd_sel}), 64'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("reset_data", 64'(out_data), 64'(0));
    check_eq("reset_flags", 64'({out_valid, busy, done}), 64'(0));
    check_eq("reset_state", 64'(dbg_state), 64'(IDLE));

    // full dump from 0 with latency check
    clear_stats();
    expect_range(0, 16);
    pulse_start(0, 16);
    check_eq("lat_fetch_valid", 64'(out_valid), 64'(0));
    check_eq("lat_fetch_busy", 64'(busy), 64'(1));
    check_eq("lat_fetch_sel", 64'(rd_sel), 64'(0));
    tick();
    check_eq("lat_first_valid", 64'(out_valid), 64'(1));
    check_eq("lat_first_word", 64'({out_idx, out_data}), 64'({4'd0, 32'hFFFF_FF00}));
    wait_done("full", 80, 16);

    // wrapping range 14,15,0,1
    clear_stats();
    expect_range(14, 4);
    pulse_start(14, 4);
    wait_done("wrap", 40, 4);

    // count of zero
    clear_stats();
    pulse_start(3, 0);
    check_eq("zero_done", 64'(done), 64'(1));
    check_eq("zero_busy", 64'(busy), 64'(1));
    wait_done("zero", 4, 0);
    check_eq("zero_no_valid", 64'(valid_cycles), 64'(0));

    // stall on word 3
    clear_stats();
    expect_range(0, 6);
    pulse_start(0, 6);
    wait_word("stall", 3, 40);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("stall_hold", 64'({out_valid, out_idx, out_data}), 64'({1'b1, 4'd3, 32'hFFFF_FF03}));
    end
    out_ready = 1'b1;
    wait_done("stall", 40, 6);

    // start while busy is ignored
    clear_stats();
    expect_range(2, 5);
    pulse_start(2, 5);
    repeat (3) tick();
    start_idx = SW'(8);
    count = (SW+1)'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore", 60, 5);

    // reset mid-dump, then a fresh dump
    clear_stats();
    expect_range(0, 10);
    pulse_start(0, 10);
    wait_word("abort", 5, 60);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_outputs", 64'({out_valid, busy, done, out_idx, rd_sel}), 64'(0));
    check_eq("abort_data", 64'(out_data), 64'(0));
    tick();
    tick();
    check_eq("abort_no_done", 64'({done, busy}), 64'(0));
    rst_n = 1'b1;
    tick();
    check_eq("abort_done_count", 64'(done_cnt), 64'(0));
    clear_stats();
    expect_range(13, 5);
    pulse_start(13, 5);
    wait_done("after_abort", 40, 5);

`ifdef REGDUMP_PARITY_EN
    regs[1] = 32'h0000_0003;
    regs[2] = 32'h0000_0007;
    clear_stats();
    expect_range(1, 2);
    pulse_start(1, 2);
    tick();
    check_eq("par_even", 64'({out_idx, out_par}), 64'({4'd1, 1'b0}));
    tick();
    tick();
    check_eq("par_odd", 64'({out_idx, out_par}), 64'({4'd2, 1'b1}));
    wait_done("par", 20, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side sequencer for the 16 x 32-bit register file.
- On a start pulse it walks a range of register indices and drives the read-mux select, one index at a time.
- It captures each read word and streams it out over a valid/ready handshake, tagged with its index.
- Used for register-file readback, debug dumps and context save; it is the reader counterpart to the decoder-driven write path.

Parameters:
- DATA_W, 32, width of one register word.
- NUM_REGS, 16, number of registers in the file; must be a power of 2.
- SEL_W, 4, select width; equals log2(NUM_REGS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- start_idx  input  SEL_W  first register index; latched on accepted start.
- count  input  SEL_W+1  number of registers to read, 0..NUM_REGS; latched on accepted start.
- rd_sel  output  SEL_W  select driven to the register-file read mux.
- rd_data  input  DATA_W  combinational mux output for rd_sel.
- out_data  output  DATA_W  captured register word.
- out_idx  output  SEL_W  index that out_data was read from.
- out_valid  output  1  out_data/out_idx are valid.
- out_ready  input  1  downstream accepts the word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, rst_n low) values: state=IDLE; rd_sel=0; out_data=0; out_idx=0; out_valid=0; busy=0; done=0; internal index and remaining-count registers = 0.
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE:
  - start=1 with count!=0 -> latch idx=start_idx and rem=count, go to FETCH.
  - start=1 with count==0 -> go to FINISH; no words are emitted.
  - start=0 -> stay in IDLE.
- FETCH (exactly one cycle):
  - rd_sel=idx for the whole cycle.
  - At the clock edge: out_data<=rd_data, out_idx<=idx, out_valid<=1, go to SEND.
- SEND:
  - out_valid is held high; out_data and out_idx are held stable until out_valid && out_ready.
  - On transfer with rem>1: rem<=rem-1; idx<=idx+1 mod NUM_REGS, wrapping 15 -> 0; out_valid<=0; go to FETCH.
  - On transfer with rem==1: out_valid<=0; go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done goes low.
- rd_sel holds its last value outside FETCH.
- Latency: start -> first out_valid = 2 cycles. With out_ready held high, one word every 2 cycles.
- A full dump (count=16) emits every register exactly once, in order, wrapping from any start_idx.
- start while busy is ignored; the latched range is not disturbed.
- start_idx and count changing after the accepting edge have no effect.
- Asserting rst_n low mid-dump aborts immediately to the reset values; no done pulse is produced.
- out_ready asserted with out_valid=0 has no effect.

Optional Feature:
- Macro: REGDUMP_PARITY_EN.
- Defined: adds an output port out_par (1 bit), the even parity (XOR-reduce) of the word captured in FETCH. It is registered alongside out_data, held stable through SEND, and resets to 0.
- Undefined: out_par does not exist; all other behaviour is identical.

Decomposition:
- Shared package regdump_pkg:
  - state enum {IDLE, FETCH, SEND, FINISH};
  - DATA_W and NUM_REGS defaults;
  - SEL_W derived as $clog2(NUM_REGS).
- No sub-module. The optional parity is a single XOR-reduce inside the block.

Test Plan:
- Register file preloaded with reg[i]=FFFFFF00+i; start_idx=0, count=16, out_ready=1 -> 16 words FFFFFF00..FFFFFF0F with out_idx 0..15; first out_valid 2 cycles after start; then a single done pulse.
- start_idx=14, count=4 -> out_idx sequence 14,15,0,1 with matching data FFFFFF0E, FFFFFF0F, FFFFFF00, FFFFFF01.
- count=0 -> no out_valid at all; done asserted in the cycle after start; busy high for exactly that cycle.
- out_ready low for 5 cycles during word index 3 -> out_valid, out_data=FFFFFF03 and out_idx=3 all stay stable; no duplicate or skipped index after out_ready rises.
- Second start pulsed mid-dump with start_idx=8 -> ignored; the original sequence completes unchanged.
- rst_n pulsed low during word 5 -> all outputs return to 0 asynchronously and no done pulse; a fresh start afterwards dumps correctly.
- With REGDUMP_PARITY_EN: reg=00000003 -> out_par=0; reg=00000007 -> out_par=1.
